uart_rx_ex: RTL and testbench
=============================

# uart_rx_ex

Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, parity, stop-bit count and oversampling ratio, false-start rejection, per-word parity/framing error flags, and an output FIFO with valid/ready handshake and overrun reporting. Sits between the board RX pin (via the shared baud tick generator) and the game-protocol parser, which can now stall without losing bytes.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- OVERSAMPLE, 16, s_tick pulses per bit period (even, 8..16)
- STOP_BITS, 1, stop bits checked (1 or 2)
- PARITY, 0, 0 none / 1 odd / 2 even
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- rx  in  1  asynchronous serial line, idle high
- s_tick  in  1  one-clk-wide oversample strobe, OVERSAMPLE per bit
- dout  out  DATA_WIDTH  FIFO head word, LSB = first received bit
- dout_parity_err  out  1  parity error flag of head word
- dout_frame_err  out  1  framing error flag of head word
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts head when dout_valid & dout_ready
- overrun  out  1  one-cycle pulse: completed word dropped, FIFO full
- busy  out  1  receiver FSM not in IDLE

## Operation
- rx passes a 2-flop synchronizer (reset to 1); rx_s = second flop. Start edge = rx_s previous 1, current 0, evaluated every clk.
- Tick counter s (width ceil(log2(OVERSAMPLE))) and bit counter n advance only on cycles with s_tick=1.
- FSM states:
  - IDLE: s=0. Start edge → START.
  - START: on s_tick, s increments; at s = OVERSAMPLE/2-1 sample rx_s: 1 → false start, back to IDLE, nothing pushed; 0 → s=0, n=0, DATA.
  - DATA: on s_tick at s = OVERSAMPLE-1 shift rx_s into MSB of shift register (LSB-first), s=0; after DATA_WIDTH bits → PARITY if PARITY≠0 else STOP; else n+1.
  - PARITY: sample at s = OVERSAMPLE-1; parity_err = (XOR of data bits XOR sampled bit) ≠ (PARITY==1). → STOP.
  - STOP: sample each stop bit at s = OVERSAMPLE-1; any 0 sample sets frame_err. After STOP_BITS samples: push {frame_err, parity_err, data}, → IDLE same cycle.
- Words with errors are still pushed, flags alongside. Error flags cleared on entering START.
- FIFO: first-word fall-through; dout/flags show head whenever dout_valid=1; pointers wrap modulo FIFO_DEPTH, count width log2(FIFO_DEPTH)+1.
- Push while full with no pop: word dropped, overrun=1 for that cycle, FIFO contents unchanged. Push and pop same cycle while full: both succeed, no overrun. Pop while empty ignored.
- dout holds last value when FIFO empty (not cleared).

## Timing
- Reset values: dout=0, flags=0, dout_valid=0, overrun=0, busy=0, FIFO empty, FSM IDLE, synchronizer=1.
- Reset mid-frame: abort frame, flush FIFO, no push, no overrun pulse; receiver rearms on next start edge after reset deasserts.
- Start edge detected 2 clk after rx falls (synchronizer); busy rises the cycle after detection.
- Push occurs on clk cycle carrying the final stop-bit sampling s_tick; dout_valid=1 on next clk.
- Frame length ≈ OVERSAMPLE/2 + OVERSAMPLE·(DATA_WIDTH + (PARITY≠0) + STOP_BITS) ticks from start edge; back-to-back frames accepted since IDLE is entered at mid-stop-bit.
- Pop: dout_valid & dout_ready at edge k → next head (or dout_valid=0) visible at k+1.
- Stop bit low with rx returning high later: frame_err=1; a continuous low line (break) produces one word 0 with frame_err=1, then no new start until rx_s returns high and falls again.

## Test plan
- Default params, s_tick every 4 clk, send 0xA5 8N1, dout_ready=1 → one word dout=0xA5, both flags 0, dout_valid high ≥1 cycle, overrun never.
- PARITY=2, send 0x3C with parity bit 1 → dout=0x3C, parity_err=1; same byte with parity bit 0 → parity_err=0; PARITY=1, 0x01 with parity 0 → parity_err=0.
- STOP_BITS=2, send 0x5A with second stop bit 0 → dout=0x5A, frame_err=1; DATA_WIDTH=7, 0x7F → dout=7'h7F.
- Glitch: rx low for 4 ticks then high → no push, busy returns 0 after ~8 ticks, next valid frame 0x11 received correctly.
- FIFO_DEPTH=4, dout_ready=0, send 0x01..0x05 → 4 stored, overrun pulses exactly once (on 0x05), then draining yields 0x01,0x02,0x03,0x04 in order, dout_valid=0 after.
- Assert reset mid-DATA of 0xC3 with 2 words queued → FIFO empty, outputs at reset values; subsequent 0x96 received as sole word.

Source files
------------

// File: rtl/uart_rx_ex.sv
// Parametrised UART receiver with false-start rejection,
// parity/framing flags and a first-word fall-through output FIFO.
module uart_rx_ex #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  s_tick,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_parity_err,
  output logic                  dout_frame_err,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_WIDTH + 2;

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_DATA = NW'(DATA_WIDTH - 1);
  localparam logic [NW-1:0] N_STOP = NW'(STOP_BITS - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic          P_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t                  state;
  logic [SW-1:0]           s;
  logic [NW-1:0]           n;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    perr, ferr;
  logic                    rx_m, rx_s, rx_p;
  logic                    start_edge, sample;
  logic                    push, pop, full, wr_en;
  logic [WW-1:0]           word, head;
  logic [WW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr, rd_nx;
  logic [CW-1:0]           count;

  // Two-flop synchronizer plus previous value for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  assign start_edge = rx_p & ~rx_s;
  assign sample     = s_tick & (s == S_END);

  // Frame FSM: tick/bit counting, data shift, error capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          s <= '0;
          if (start_edge) begin
            state <= START;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        START: if (s_tick) begin
          if (s == S_MID) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
        DATA: if (s_tick) begin
          if (s == S_END) begin
            s     <= '0;
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
            if (n == N_DATA) begin
              n     <= '0;
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
        PAR: if (s_tick) begin
          if (s == S_END) begin
            s     <= '0;
            perr  <= ((^shreg) ^ rx_s) != P_ODD;
            state <= STOP;
          end else begin
            s <= s + 1'b1;
          end
        end
        STOP: if (s_tick) begin
          if (s == S_END) begin
            s    <= '0;
            ferr <= ferr | ~rx_s;
            if (n == N_STOP) begin
              state <= IDLE;
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completed word is offered to the FIFO on the final stop sample
  always_comb begin
    push = ~reset & (state == STOP) & sample & (n == N_STOP);
    word = {ferr | ~rx_s, perr, shreg};
  end

  assign busy       = (state != IDLE);
  assign dout_valid = (count != '0);
  assign pop        = dout_valid & dout_ready;
  assign full       = (count == C_FULL);
  assign wr_en      = push & (~full | pop);
  assign overrun    = push & full & ~pop;
  assign rd_nx      = rd_ptr + 1'b1;

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word;
  end

  // FIFO pointers, occupancy and registered head word
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_nx;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        if (count > CW'(1)) head <= mem[rd_nx];
        else if (wr_en)     head <= word;
      end else if (wr_en && count == '0) begin
        head <= word;
      end
    end
  end

  assign {dout_frame_err, dout_parity_err, dout} = head;

endmodule

// File: tb/tb_uart_rx_ex.sv
// Bench for uart_rx_ex: three parameter sets, table vectors,
// random frames against a bit-level model, FIFO/reset/break corners.
module tb_uart_rx_ex;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [2:0] rxl = 3'b111;
  logic [2:0] rdy = 3'b000;
  logic [2:0] vq, pe, fe, ov, bz;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [7:0] dq [3];

  int npass = 0;
  int ntot  = 0;
  int ovc [3] = '{0, 0, 0};
  int tc = 0;

  typedef struct {
    int         inst;
    logic [7:0] d;
    bit         pb;
    bit   [1:0] st;
    logic [7:0] ed;
    bit         ep;
    bit         ef;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  always_comb begin
    dq[0] = d0;
    dq[1] = d1;
    dq[2] = {1'b0, d2};
  end

  uart_rx_ex u0 (
    .clk(clk), .reset(reset), .rx(rxl[0]), .s_tick(s_tick),
    .dout(d0), .dout_parity_err(pe[0]), .dout_frame_err(fe[0]),
    .dout_valid(vq[0]), .dout_ready(rdy[0]),
    .overrun(ov[0]), .busy(bz[0]));

  uart_rx_ex #(.PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(reset), .rx(rxl[1]), .s_tick(s_tick),
    .dout(d1), .dout_parity_err(pe[1]), .dout_frame_err(fe[1]),
    .dout_valid(vq[1]), .dout_ready(rdy[1]),
    .overrun(ov[1]), .busy(bz[1]));

  uart_rx_ex #(.DATA_WIDTH(7), .OVERSAMPLE(8), .PARITY(1)) u2 (
    .clk(clk), .reset(reset), .rx(rxl[2]), .s_tick(s_tick),
    .dout(d2), .dout_parity_err(pe[2]), .dout_frame_err(fe[2]),
    .dout_valid(vq[2]), .dout_ready(rdy[2]),
    .overrun(ov[2]), .busy(bz[2]));

  // oversample strobe: one clk in every four
  initial forever begin
    @(posedge clk);
    #1;
    s_tick = (tc == 3);
    tc = (tc + 1) % 4;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (ov[i] === 1'b1) ovc[i]++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

  function automatic void chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endfunction

  task automatic tick_clk(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int osf(int i);
    return (i == 2) ? 8 : 16;
  endfunction

  task automatic send_bit(int i, bit v);
    rxl[i] = v;
    tick_clk(osf(i) * 4);
  endtask

  task automatic send(int i, logic [7:0] d, bit pb, bit [1:0] st);
    int dw;
    dw = (i == 2) ? 7 : 8;
    send_bit(i, 1'b0);
    for (int k = 0; k < dw; k++) send_bit(i, d[k]);
    if (i != 0) send_bit(i, pb);
    send_bit(i, st[0]);
    if (i == 1) send_bit(i, st[1]);
    rxl[i] = 1'b1;
    tick_clk(osf(i) * 8);
  endtask

  task automatic wait_valid(int i);
    int w;
    w = 0;
    while (vq[i] !== 1'b1 && w < 400) begin
      tick_clk(1);
      w++;
    end
  endtask

  task automatic expect_word(int i, string nm, logic [7:0] ed,
                             bit ep, bit ef);
    wait_valid(i);
    chk({nm, " valid"}, int'(vq[i]), 1);
    chk({nm, " dout"}, int'(dq[i]), int'(ed));
    chk({nm, " perr"}, int'(pe[i]), int'(ep));
    chk({nm, " ferr"}, int'(fe[i]), int'(ef));
    rdy[i] = 1'b1;
    tick_clk(1);
    rdy[i] = 1'b0;
    chk({nm, " empty"}, int'(vq[i]), 0);
  endtask

  initial begin
    int         i, ones, c;
    logic [7:0] d;
    bit         pb, ep, ef;
    bit   [1:0] st;

    tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{2, 8'h01, 1'b0, 2'b01, 8'h01, 1'b0, 1'b0};
    tbl[4] = '{1, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    tbl[5] = '{2, 8'h7F, 1'b0, 2'b01, 8'h7F, 1'b0, 1'b0};
    tbl[6] = '{0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
    tbl[8] = '{2, 8'h55, 1'b0, 2'b01, 8'h55, 1'b1, 1'b0};
    tbl[9] = '{1, 8'h81, 1'b1, 2'b10, 8'h81, 1'b1, 1'b1};

    reset = 1'b1;
    tick_clk(5);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst dout%0d", k), int'(dq[k]), 0);
      chk($sformatf("rst valid%0d", k), int'(vq[k]), 0);
      chk($sformatf("rst busy%0d", k), int'(bz[k]), 0);
      chk($sformatf("rst ovr%0d", k), int'(ov[k]), 0);
      chk($sformatf("rst flags%0d", k), int'({pe[k], fe[k]}), 0);
    end
    reset = 1'b0;
    tick_clk(5);

    for (int k = 0; k < 10; k++) begin
      send(tbl[k].inst, tbl[k].d, tbl[k].pb, tbl[k].st);
      expect_word(tbl[k].inst, $sformatf("vec%0d", k),
                  tbl[k].ed, tbl[k].ep, tbl[k].ef);
    end

    for (int k = 0; k < 24; k++) begin
      i  = $urandom_range(0, 2);
      d  = 8'($urandom);
      pb = 1'($urandom);
      st = 2'($urandom);
      if (i == 2) d[7] = 1'b0;
      ones = $countones(d);
      if (i == 0) ep = 1'b0;
      else ep = (((ones + int'(pb)) % 2) == 1) != (i == 2);
      ef = !st[0] || (i == 1 && !st[1]);
      send(i, d, pb, st);
      expect_word(i, $sformatf("rnd%0d", k), d, ep, ef);
    end
    chk("rnd no overrun", ovc[0] + ovc[1] + ovc[2], 0);

    rxl[0] = 1'b0;
    tick_clk(8);
    chk("glitch busy", int'(bz[0]), 1);
    tick_clk(8);
    rxl[0] = 1'b1;
    tick_clk(40);
    chk("glitch idle", int'(bz[0]), 0);
    chk("glitch nopush", int'(vq[0]), 0);
    send(0, 8'h11, 1'b0, 2'b11);
    expect_word(0, "after glitch", 8'h11, 1'b0, 1'b0);

    c = ovc[0];
    for (int k = 1; k <= 4; k++) send(0, 8'(k), 1'b0, 2'b11);
    chk("ovr none at 4", ovc[0] - c, 0);
    send(0, 8'h05, 1'b0, 2'b11);
    chk("ovr once", ovc[0] - c, 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("drain valid%0d", k), int'(vq[0]), 1);
      chk($sformatf("drain dout%0d", k), int'(dq[0]), k);
      rdy[0] = 1'b1;
      tick_clk(1);
      rdy[0] = 1'b0;
    end
    chk("drain empty", int'(vq[0]), 0);
    chk("drain dout held", int'(dq[0]), 4);

    send(0, 8'h21, 1'b0, 2'b11);
    send(0, 8'h22, 1'b0, 2'b11);
    chk("pre-rst queued", int'(vq[0]), 1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    c = ovc[0];
    reset = 1'b1;
    rxl[0] = 1'b1;
    tick_clk(3);
    chk("midrst valid", int'(vq[0]), 0);
    chk("midrst dout", int'(dq[0]), 0);
    chk("midrst busy", int'(bz[0]), 0);
    reset = 1'b0;
    tick_clk(10);
    chk("midrst no ovr", ovc[0] - c, 0);
    send(0, 8'h96, 1'b0, 2'b11);
    expect_word(0, "post rst", 8'h96, 1'b0, 1'b0);

    rxl[0] = 1'b0;
    tick_clk(64 * 20);
    expect_word(0, "break", 8'h00, 1'b0, 1'b1);
    tick_clk(64 * 5);
    chk("break single", int'(vq[0]), 0);
    chk("break idle", int'(bz[0]), 0);
    rxl[0] = 1'b1;
    tick_clk(64);
    send(0, 8'h3E, 1'b0, 2'b11);
    expect_word(0, "after break", 8'h3E, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
